mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single address/data/write_enable port of the 32-entry memory bank between two requesters.
- Port A is the CPU datapath; port B is the debug/loader.
- Round-robin arbitration with a req/gnt handshake; read data is returned registered one cycle after grant.
- All memory-port accesses are blocked while the scan chain is in use.

Parameters:
- ADDR_WIDTH, 5, memory address width
- DATA_WIDTH, 8, memory data width
- IO_ADDR, 31, address of the LED/button IO register in the memory bank

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- a_req  input  1  requester A access request; held with payload stable until a_gnt
- a_we  input  1  A: 1 = write, 0 = read
- a_addr  input  ADDR_WIDTH  A access address
- a_wdata  input  DATA_WIDTH  A write data
- a_gnt  output  1  one-cycle pulse; A's access is performed this cycle
- a_rvalid  output  1  one-cycle pulse, cycle after a read grant
- a_rdata  output  DATA_WIDTH  A read data, valid with a_rvalid, held until next A read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A ports, for requester B
- scan_enable  input  1  memory scan chain active; no grants issued
- mem_address  output  ADDR_WIDTH  to memory address
- mem_data_in  output  DATA_WIDTH  to memory data_in
- mem_write_enable  output  1  to memory write_enable
- mem_data_out  input  DATA_WIDTH  from memory data_out (combinational read)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, rr_last=B (A wins first tie).
  - All gnt, rvalid, mem_write_enable are 0.
  - rdata, mem_address and mem_data_in are all zeros.
- Registered outputs and state: IDLE, SERVE_A, SERVE_B, SCAN_HOLD.
- Arbitration happens at every rising edge while in IDLE, SERVE_A or SERVE_B.
  - Eligible: a_req=1 (ignored if current state is SERVE_A); same rule for B with SERVE_B.
  - Eligibility means one grant per request, and a requester is granted at most every other cycle.
  - Both eligible: grant the requester that is not rr_last. Single eligible: grant it. None: go to IDLE.
  - On grant, latch addr/we/wdata into the mem_* registers, enter SERVE_x, set rr_last=x.
- In SERVE_x (exactly one cycle):
  - x_gnt=1.
  - mem_address and mem_data_in are driven from the latched values.
  - mem_write_enable = latched we.
- Read capture: at the end of a SERVE_x cycle with we=0, register mem_data_out into x_rdata; x_rvalid=1 the next cycle.
- Write: no rvalid; x_rdata is unchanged.
- Latency: req seen high at edge N → gnt in cycle N..N+1 → rvalid in cycle N+1..N+2.
  - Back-to-back alternation A,B,A,B reaches 1 access per cycle.
- Outside SERVE: mem_write_enable=0; mem_address/mem_data_in hold their last values.
- Requester protocol: after gnt, a requester may drop req or present a new payload in the next cycle. A req still high in the gnt cycle's closing edge is not re-granted at that edge.
- scan_enable=1 sampled at an edge:
  - From IDLE or SERVE, enter SCAN_HOLD. A SERVE in progress completes first, because it is already one cycle.
  - In SCAN_HOLD there are no grants and mem_write_enable=0.
  - Pending reqs wait. Exit to arbitration at the first edge with scan_enable=0.
- rvalid for an access served just before SCAN_HOLD still fires.
- Reset mid-access: outputs clear immediately; the outstanding access is lost and no rvalid is issued.

Optional Feature:
- Macro MEM_ARB_IO_LOCK_EN.
- Defined: a B write to IO_ADDR is still granted (b_gnt pulses) but mem_write_enable is forced to 0 that cycle, and output b_err (1 bit, reset 0) pulses in the same cycle. B reads of IO_ADDR are unaffected; A is never locked.
- Undefined: no b_err port; B writes IO_ADDR normally.

Test Plan:
- Reset, then A read addr 3 (mem[3]=0x5A) → a_gnt 1 cycle after req sampled, mem_address=3, mem_write_enable=0; a_rvalid next cycle with a_rdata=0x5A.
- a_req and b_req both held high continuously with new payloads after each grant → grants alternate A,B,A,B one per cycle, starting with A after reset.
- B write 0xC3 to addr 10, then B read addr 10 → mem_write_enable=1 for exactly 1 cycle with mem_data_in=0xC3; read returns b_rdata=0xC3; no rvalid for the write.
- scan_enable raised while A is requesting → no a_gnt and mem_write_enable=0 for the whole scan window; a_gnt appears 1 cycle after scan_enable falls.
- rst pulled low during SERVE_B of a read → b_gnt and mem_write_enable drop asynchronously; no b_rvalid; after release the first tie goes to A.
- MEM_ARB_IO_LOCK_EN defined: B write 0xFE to addr 31 → b_gnt=1, b_err=1, mem_write_enable=0, LED value unchanged; A write 0xFE to addr 31 → mem_write_enable=1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between CPU (A) and debug/loader (B)
// Optional: define MEM_ARB_IO_LOCK_EN to block B writes to IO_ADDR and flag them on b_err.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 8,
    parameter int IO_ADDR    = 31
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    input  logic                  scan_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_write_enable,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
`ifdef MEM_ARB_IO_LOCK_EN
    output logic                  b_err,
`endif
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, SERVE_A, SERVE_B, SCAN_HOLD} state_t;

    state_t                  r_state;
    logic                    r_rr_last_b;
    logic                    r_we;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic                    r_a_gnt, r_b_gnt;
    logic                    r_a_rvalid, r_b_rvalid;
    logic [DATA_WIDTH-1:0]   r_a_rdata, r_b_rdata;

    logic w_elig_a, w_elig_b, w_pick_a, w_pick_b, w_b_locked;

    // A requester just served is not eligible again at its own closing edge.
    assign w_elig_a = a_req && (r_state != SERVE_A);
    assign w_elig_b = b_req && (r_state != SERVE_B);
    assign w_pick_a = w_elig_a && (!w_elig_b || r_rr_last_b);
    assign w_pick_b = w_elig_b && (!w_elig_a || !r_rr_last_b);

`ifdef MEM_ARB_IO_LOCK_EN
    logic r_b_err;
    assign w_b_locked = b_we && (b_addr == ADDR_WIDTH'(IO_ADDR));
    assign b_err      = r_b_err;
`else
    assign w_b_locked = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_rr_last_b <= 1'b1;
            r_we        <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_a_rvalid  <= 1'b0;
            r_b_rvalid  <= 1'b0;
            r_a_rdata   <= '0;
            r_b_rdata   <= '0;
`ifdef MEM_ARB_IO_LOCK_EN
            r_b_err     <= 1'b0;
`endif
        end else begin
            r_a_gnt    <= 1'b0;
            r_b_gnt    <= 1'b0;
            r_mem_we   <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
`ifdef MEM_ARB_IO_LOCK_EN
            r_b_err    <= 1'b0;
`endif
            // Read capture closes the SERVE cycle even if scan takes over at this edge.
            if (r_state == SERVE_A && !r_we) begin
                r_a_rdata  <= mem_data_out;
                r_a_rvalid <= 1'b1;
            end
            if (r_state == SERVE_B && !r_we) begin
                r_b_rdata  <= mem_data_out;
                r_b_rvalid <= 1'b1;
            end

            if (scan_enable) begin
                r_state <= SCAN_HOLD;
            end else if (w_pick_a) begin
                r_state     <= SERVE_A;
                r_rr_last_b <= 1'b0;
                r_mem_addr  <= a_addr;
                r_mem_wdata <= a_wdata;
                r_we        <= a_we;
                r_mem_we    <= a_we;
                r_a_gnt     <= 1'b1;
            end else if (w_pick_b) begin
                r_state     <= SERVE_B;
                r_rr_last_b <= 1'b1;
                r_mem_addr  <= b_addr;
                r_mem_wdata <= b_wdata;
                r_we        <= b_we;
                r_mem_we    <= b_we && !w_b_locked;
                r_b_gnt     <= 1'b1;
`ifdef MEM_ARB_IO_LOCK_EN
                r_b_err     <= w_b_locked;
`endif
            end else begin
                r_state <= IDLE;
            end
        end
    end

    assign a_gnt            = r_a_gnt;
    assign b_gnt            = r_b_gnt;
    assign a_rvalid         = r_a_rvalid;
    assign b_rvalid         = r_b_rvalid;
    assign a_rdata          = r_a_rdata;
    assign b_rdata          = r_b_rdata;
    assign mem_address      = r_mem_addr;
    assign mem_data_in      = r_mem_wdata;
    assign mem_write_enable = r_mem_we;
    assign busy             = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter (honours MEM_ARB_IO_LOCK_EN)
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we, scan_enable;
    logic [4:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_write_enable, busy;
    logic [7:0] a_rdata, b_rdata, mem_data_in;
    logic [4:0] mem_address;
    logic [7:0] mem_data_out;
`ifdef MEM_ARB_IO_LOCK_EN
    logic       b_err;
`endif

    logic [7:0] tb_mem [32];
    logic [7:0] model  [32];
    logic [7:0] qa [$];
    logic [7:0] qb [$];
    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] old_led;

    always #5 clk = ~clk;

    assign mem_data_out = tb_mem[mem_address];
    always @(posedge clk) if (mem_write_enable) tb_mem[mem_address] <= mem_data_in;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .scan_enable(scan_enable),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_data_out(mem_data_out),
`ifdef MEM_ARB_IO_LOCK_EN
        .b_err(b_err),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: sample away from the edge, score grants and read returns.
    task automatic tick();
        logic locked;
        @(negedge clk);
        chk("gnt_excl", {31'd0, a_gnt & b_gnt}, 0);
        if (a_rvalid) begin
            if (qa.size() == 0) chk("a_rvalid_unexp", 1, 0);
            else chk("a_rdata", a_rdata, qa.pop_front());
        end
        if (b_rvalid) begin
            if (qb.size() == 0) chk("b_rvalid_unexp", 1, 0);
            else chk("b_rdata", b_rdata, qb.pop_front());
        end
        if (a_gnt) begin
            chk("a_mem_addr", mem_address, a_addr);
            chk("a_mem_we", mem_write_enable, a_we);
            if (a_we) begin
                chk("a_mem_din", mem_data_in, a_wdata);
                model[a_addr] = a_wdata;
            end else qa.push_back(model[a_addr]);
        end
        if (b_gnt) begin
            locked = 1'b0;
`ifdef MEM_ARB_IO_LOCK_EN
            locked = b_we && (b_addr == 5'd31);
            chk("b_err", b_err, locked);
`endif
            chk("b_mem_addr", mem_address, b_addr);
            chk("b_mem_we", mem_write_enable, b_we && !locked);
            if (b_we) begin
                if (!locked) begin
                    chk("b_mem_din", mem_data_in, b_wdata);
                    model[b_addr] = b_wdata;
                end
            end else qb.push_back(model[b_addr]);
        end
    endtask

    task automatic access(input bit is_b, input logic we, input logic [4:0] addr, input logic [7:0] data);
        bit got = 0;
        if (is_b) begin b_we = we; b_addr = addr; b_wdata = data; b_req = 1'b1; end
        else      begin a_we = we; a_addr = addr; a_wdata = data; a_req = 1'b1; end
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = is_b ? b_gnt : a_gnt;
        end
        if (!got) chk(is_b ? "b_gnt_timeout" : "a_gnt_timeout", 0, 1);
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            model[i]  = 8'(i * 3 + 1);
            tb_mem[i] = 8'(i * 3 + 1);
        end
        model[3] = 8'h5A; tb_mem[3] = 8'h5A;
        rst = 1'b0; scan_enable = 1'b0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_b_gnt", b_gnt, 0);
        chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        chk("rst_mem_we", mem_write_enable, 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_mem_din", mem_data_in, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        // A read of addr 3
        a_we = 0; a_addr = 5'd3; a_req = 1'b1;
        tick();
        chk("t1_gnt", a_gnt, 1);
        chk("t1_addr", mem_address, 3);
        a_req = 1'b0;
        tick();
        chk("t1_rvalid", a_rvalid, 1);
        chk("t1_rdata", a_rdata, 8'h5A);
        tick();
        chk("t1_rvalid_pulse", a_rvalid, 0);

        // Continuous contention alternates A,B,... from reset
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        a_we = 0; a_addr = 5'd0; b_we = 0; b_addr = 5'd16;
        a_req = 1'b1; b_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("alt_a", a_gnt, (k % 2 == 0));
            chk("alt_b", b_gnt, (k % 2 == 1));
            if (a_gnt) a_addr = a_addr + 5'd1;
            if (b_gnt) b_addr = b_addr + 5'd1;
        end
        a_req = 0; b_req = 0;
        repeat (2) tick();

        // B write then read back
        access(1'b1, 1'b1, 5'd10, 8'hC3);
        tick();
        chk("t3_we_pulse", mem_write_enable, 0);
        chk("t3_no_rvalid", b_rvalid, 0);
        access(1'b1, 1'b0, 5'd10, 8'h00);
        tick();
        chk("t3_rvalid", b_rvalid, 1);
        chk("t3_rdata", b_rdata, 8'hC3);

        // Scan window; rvalid of access served just before still fires
        access(1'b0, 1'b0, 5'd5, 8'h00);
        scan_enable = 1'b1;
        a_we = 0; a_addr = 5'd6; a_req = 1'b1;
        tick();
        chk("t4_rvalid_pre_scan", a_rvalid, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_scan_no_gnt", a_gnt, 0);
            chk("t4_scan_we", mem_write_enable, 0);
            chk("t4_scan_busy", busy, 1);
        end
        scan_enable = 1'b0;
        tick();
        chk("t4_gnt_after_scan", a_gnt, 1);
        a_req = 1'b0;
        repeat (2) tick();

        // Reset during SERVE_B of a read
        b_we = 0; b_addr = 5'd7; b_req = 1'b1;
        tick();
        chk("t5_b_gnt", b_gnt, 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_async_gnt", b_gnt, 0);
        chk("t5_async_we", mem_write_enable, 0);
        chk("t5_async_busy", busy, 0);
        qb.delete();
        b_req = 1'b0;
        tick();
        chk("t5_no_rvalid", b_rvalid, 0);
        rst = 1'b1;
        a_we = 0; a_addr = 5'd1; b_we = 0; b_addr = 5'd2;
        a_req = 1'b1; b_req = 1'b1;
        tick();
        chk("t5_tie_a", a_gnt, 1);
        chk("t5_tie_not_b", b_gnt, 0);
        a_req = 1'b0;
        tick();
        chk("t5_then_b", b_gnt, 1);
        b_req = 1'b0;
        repeat (2) tick();

        // IO register writes
        old_led = tb_mem[31];
        access(1'b1, 1'b1, 5'd31, 8'hFE);
        tick();
`ifdef MEM_ARB_IO_LOCK_EN
        chk("t6_led_locked", tb_mem[31], old_led);
`else
        chk("t6_led_b_write", tb_mem[31], 8'hFE);
`endif
        access(1'b0, 1'b1, 5'd31, 8'hFE);
        tick();
        chk("t6_led_a_write", tb_mem[31], 8'hFE);

        repeat (3) tick();
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
